// File: rtl/register_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_array_pkg
//  Description : Shared operation encoding and priority compare for the
//                sorted register-array priority queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package register_array_pkg;

   // Widest key the compare helper accepts; callers zero-extend into it.
   localparam int KEY_EXT_W = 64;

   // Decoded per-cycle operation applied to every slot.
   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_PUSH    = 3'd1,
      OP_POP     = 3'd2,
      OP_REPLACE = 3'd3,
      OP_FLUSH   = 3'd4
   } op_e;

   // Strict unsigned compare: a outranks b (larger wins in max mode,
   // smaller wins in min mode). Equal keys never beat each other, which
   // is what gives FIFO ordering among ties.
   function automatic logic beats(
      input logic [KEY_EXT_W-1:0] a,
      input logic [KEY_EXT_W-1:0] b,
      input logic                 max_mode
   );
      return max_mode ? (a > b) : (a < b);
   endfunction

endpackage
`default_nettype wire

// File: rtl/register_array_cell.sv
`default_nettype none
// ============================================================================
//  Module      : register_array_cell
//  Description : Next-state logic for one slot of the sorted register array.
//                Chooses between holding, shifting from a neighbour, taking
//                the new entry, or clearing, based on the decoded operation
//                and two precomputed compare results.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_array_cell
   import register_array_pkg::*;
#(
   parameter int SLOT_W = 25
)(
   input  op_e               i_op,
   input  logic [SLOT_W-1:0] i_new,
   input  logic [SLOT_W-1:0] i_up,
   input  logic [SLOT_W-1:0] i_own,
   input  logic [SLOT_W-1:0] i_dn,
   // New entry beats the entry that would sit in this slot after the shift
   input  logic              i_cmp_base,
   // New entry beats the entry that would sit in the slot above (0 for slot 0)
   input  logic              i_cmp_above,
   output logic [SLOT_W-1:0] o_next
);

   logic [SLOT_W-1:0] w_base;
   logic [SLOT_W-1:0] w_above;

   // A push shifts entries down (base = own, above = upper neighbour);
   // a replace first shifts up to drop slot 0 (base = lower, above = own).
   always_comb begin
      w_base  = i_own;
      w_above = i_up;
      if (i_op == OP_REPLACE) begin
         w_base  = i_dn;
         w_above = i_own;
      end
   end

   // Select the slot's next contents for the decoded operation.
   always_comb begin
      o_next = i_own;
      case (i_op)
         OP_FLUSH: o_next = '0;
         OP_POP:   o_next = i_dn;
         OP_PUSH, OP_REPLACE: begin
            if (!i_cmp_base)
               o_next = w_base;   // new entry lands further down
            else if (i_cmp_above)
               o_next = w_above;  // new entry lands further up
            else
               o_next = i_new;    // this slot is the insert position
         end
         default:  o_next = i_own;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/register_array_pq.sv
`default_nettype none
// ============================================================================
//  Module      : register_array_pq
//  Description : Fully sorted register-array priority queue of key+payload
//                entries, max- or min-ordered, FIFO on ties. One push, pop,
//                replace or flush per clock; top entry read from slot 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_array_pq
   import register_array_pkg::*;
#(
   parameter int QUEUE_SIZE = 8,
   parameter int KEY_WIDTH  = 16,
   parameter int VAL_WIDTH  = 8,
   parameter int MAX_QUEUE  = 1,
   parameter int CNT_WIDTH  = $clog2(QUEUE_SIZE + 1)
)(
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 i_wrt,
   input  logic                 i_read,
   input  logic                 i_flush,
   input  logic [KEY_WIDTH-1:0] i_key,
   input  logic [VAL_WIDTH-1:0] i_val,
   output logic [KEY_WIDTH-1:0] o_key,
   output logic [VAL_WIDTH-1:0] o_val,
   output logic                 o_valid,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [CNT_WIDTH-1:0] o_count,
   output logic                 o_overflow,
   output logic                 o_underflow
);

   // Slot layout: {valid, key, val}
   localparam int                   SLOT_W     = 1 + KEY_WIDTH + VAL_WIDTH;
   localparam int                   VLD_BIT    = SLOT_W - 1;
   localparam int                   KEY_HI     = KEY_WIDTH + VAL_WIDTH - 1;
   localparam logic [CNT_WIDTH-1:0] C_FULL_CNT = CNT_WIDTH'(QUEUE_SIZE);
   localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);
   localparam logic                 C_MAX_MODE = (MAX_QUEUE != 0);

   logic [SLOT_W-1:0]    r_slot [QUEUE_SIZE];
   logic [SLOT_W-1:0]    w_next [QUEUE_SIZE];
   // w_gt[i]: new entry beats slot i; the virtual slot past the end is
   // always beaten so the tail behaves like an invalid entry.
   logic [QUEUE_SIZE:0]  w_gt;
   logic [SLOT_W-1:0]    w_new;
   op_e                  w_op;
   logic                 w_ovf;
   logic                 w_udf;
   logic                 w_full;
   logic                 w_empty;
   logic [CNT_WIDTH-1:0] r_count;
   logic [CNT_WIDTH-1:0] w_count_next;
   logic                 r_overflow;
   logic                 r_underflow;

   assign w_new   = {1'b1, i_key, i_val};
   assign w_full  = (r_count == C_FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_gt[QUEUE_SIZE] = 1'b1;

   // Decode the request in priority order and apply the full/empty guards.
   always_comb begin
      w_op  = OP_NOP;
      w_ovf = 1'b0;
      w_udf = 1'b0;
      if (i_flush) begin
         w_op = OP_FLUSH;
      end else if (i_wrt && i_read) begin
         // Replace on an empty queue has nothing to remove: plain push.
         w_op = w_empty ? OP_PUSH : OP_REPLACE;
      end else if (i_wrt) begin
         if (w_full) w_ovf = 1'b1;
         else        w_op  = OP_PUSH;
      end else if (i_read) begin
         if (w_empty) w_udf = 1'b1;
         else         w_op  = OP_POP;
      end
   end

   // Occupancy follows the accepted operation; guards keep it from wrapping.
   always_comb begin
      w_count_next = r_count;
      case (w_op)
         OP_FLUSH: w_count_next = '0;
         OP_PUSH:  w_count_next = r_count + C_ONE;
         OP_POP:   w_count_next = r_count - C_ONE;
         default:  w_count_next = r_count;
      endcase
   end

   // Per-slot compare, neighbour wiring and next-state cell.
   for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_slot
      logic [SLOT_W-1:0] w_up;
      logic [SLOT_W-1:0] w_dn;
      logic              w_cmp_base;
      logic              w_cmp_above;

      // Invalid slots rank below everything, so the new entry beats them.
      assign w_gt[i] = !r_slot[i][VLD_BIT] ||
                       beats(KEY_EXT_W'(i_key),
                             KEY_EXT_W'(r_slot[i][KEY_HI:VAL_WIDTH]),
                             C_MAX_MODE);

      // Replace looks one slot further down because slot 0 is being removed.
      assign w_cmp_base = (w_op == OP_REPLACE) ? w_gt[i+1] : w_gt[i];

      if (i == 0) begin : g_head
         assign w_up        = '0;
         assign w_cmp_above = 1'b0;
      end else begin : g_body
         assign w_up        = r_slot[i-1];
         assign w_cmp_above = (w_op == OP_REPLACE) ? w_gt[i] : w_gt[i-1];
      end

      if (i == QUEUE_SIZE - 1) begin : g_tail
         assign w_dn = '0;
      end else begin : g_inner
         assign w_dn = r_slot[i+1];
      end

      register_array_cell #(
         .SLOT_W (SLOT_W)
      ) u_cell (
         .i_op        (w_op),
         .i_new       (w_new),
         .i_up        (w_up),
         .i_own       (r_slot[i]),
         .i_dn        (w_dn),
         .i_cmp_base  (w_cmp_base),
         .i_cmp_above (w_cmp_above),
         .o_next      (w_next[i])
      );
   end

   // Slot storage: every slot updates each edge from its cell.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int j = 0; j < QUEUE_SIZE; j++) r_slot[j] <= '0;
      end else begin
         for (int j = 0; j < QUEUE_SIZE; j++) r_slot[j] <= w_next[j];
      end
   end

   // Occupancy counter and one-cycle drop flags.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_next;
         r_overflow  <= w_ovf;
         r_underflow <= w_udf;
      end
   end

   assign o_key       = r_slot[0][KEY_HI:VAL_WIDTH];
   assign o_val       = r_slot[0][VAL_WIDTH-1:0];
   assign o_valid     = r_slot[0][VLD_BIT];
   assign o_full      = w_full;
   assign o_empty     = w_empty;
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule
`default_nettype wire
